// File: rtl/sparse_value_packer_pkg.sv
// Shared definitions for the sparse value packer: FSM encoding, the
// index-width sanity check and the value-slice helper.
package sparse_value_packer_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HEADER = 2'd1,
      EMIT   = 2'd2
   } state_t;

   // Prefix counts reach BITMASK_LENGTH, so the index must hold that value.
   function automatic bit index_width_ok(input int mask_len, input int idx_w);
      return (64'd1 << idx_w) > 64'(mask_len);
   endfunction

   // MSB of value i inside the packed value bus; use with -: vw.
   function automatic int value_msb(input int idx, input int vw);
      return (idx + 1) * vw - 1;
   endfunction

endpackage

// File: rtl/sparse_value_packer_select.sv
// selectGenerator: inclusive prefix popcount of a mask, P[i] = ones in mask[i:0].
module selectGenerator #(
   parameter int BITMASK_LENGTH = 16,
   parameter int INDEX_BITWIDTH = 5
) (
   input  logic [BITMASK_LENGTH-1:0]                     i_mask,
   output logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] o_prefix
);

   logic [INDEX_BITWIDTH-1:0] w_acc;

   always_comb begin
      w_acc    = '0;
      o_prefix = '0;
      for (int i = 0; i < BITMASK_LENGTH; i++) begin
         w_acc       = w_acc + INDEX_BITWIDTH'(i_mask[i]);
         o_prefix[i] = w_acc;
      end
   end

endmodule

// File: rtl/sparse_value_packer.sv
// Packs one dense block into a header beat (mask) followed by only the kept
// values, LSB first, on a valid/ready stream.
module sparse_value_packer
   import sparse_value_packer_pkg::*;
#(
   parameter int BITMASK_LENGTH = 16,
   parameter int INDEX_BITWIDTH = 5,
   parameter int VALUE_WIDTH    = 8
) (
   input  logic                                  clock,
   input  logic                                  resetn,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [BITMASK_LENGTH-1:0]             in_mask,
   input  logic [VALUE_WIDTH*BITMASK_LENGTH-1:0] in_values,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic                                  out_is_header,
   output logic [BITMASK_LENGTH-1:0]             out_mask,
   output logic [VALUE_WIDTH-1:0]                out_data,
   output logic                                  out_last,
   output state_t                                o_dbg_state
);

   // Handshake: a transfer happens on a rising edge where valid && ready;
   // out_* is held stable while out_valid && !out_ready.

   if (!index_width_ok(BITMASK_LENGTH, INDEX_BITWIDTH)) begin : g_bad_index_width
      $error("INDEX_BITWIDTH too small for BITMASK_LENGTH");
   end

   state_t                                r_state;
   logic [INDEX_BITWIDTH-1:0]             r_cursor;
   logic [INDEX_BITWIDTH-1:0]             r_count;
   logic [BITMASK_LENGTH-1:0]             r_mask;
   logic [VALUE_WIDTH*BITMASK_LENGTH-1:0] r_values;

   state_t                                    w_next_state;
   logic [INDEX_BITWIDTH-1:0]                 w_next_cursor;
   logic                                      w_load;
   logic [INDEX_BITWIDTH-1:0]                 w_in_count;
   logic [VALUE_WIDTH-1:0]                    w_sel_data;
   logic [BITMASK_LENGTH-1:0][INDEX_BITWIDTH-1:0] w_prefix;

   selectGenerator #(
      .BITMASK_LENGTH (BITMASK_LENGTH),
      .INDEX_BITWIDTH (INDEX_BITWIDTH)
   ) u_select (
      .i_mask   (r_mask),
      .o_prefix (w_prefix)
   );

   always_comb begin
      w_in_count = '0;
      for (int i = 0; i < BITMASK_LENGTH; i++) begin
         w_in_count = w_in_count + INDEX_BITWIDTH'(in_mask[i]);
      end
   end

   // Exactly one kept value has prefix count equal to the cursor.
   always_comb begin
      w_sel_data = '0;
      for (int i = 0; i < BITMASK_LENGTH; i++) begin
         if (r_mask[i] && (w_prefix[i] == r_cursor)) begin
            w_sel_data = w_sel_data | r_values[value_msb(i, VALUE_WIDTH) -: VALUE_WIDTH];
         end
      end
   end

   always_comb begin
      w_next_state  = r_state;
      w_next_cursor = r_cursor;
      w_load        = 1'b0;
      in_ready      = 1'b0;
      out_valid     = 1'b0;
      out_is_header = 1'b0;
      out_mask      = '0;
      out_data      = '0;
      out_last      = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_load       = 1'b1;
               w_next_state = HEADER;
            end
         end
         HEADER: begin
            out_valid     = 1'b1;
            out_is_header = 1'b1;
            out_mask      = r_mask;
            out_last      = (r_count == '0);
            if (out_ready) begin
               if (r_count == '0) begin
                  w_next_state = IDLE;
               end else begin
                  w_next_state  = EMIT;
                  w_next_cursor = INDEX_BITWIDTH'(1);
               end
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_data  = w_sel_data;
            out_last  = (r_cursor == r_count);
            if (out_ready) begin
               if (r_cursor == r_count) begin
                  w_next_state  = IDLE;
                  w_next_cursor = '0;
               end else begin
                  w_next_cursor = r_cursor + INDEX_BITWIDTH'(1);
               end
            end
         end
         default: begin
            w_next_state  = IDLE;
            w_next_cursor = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state  <= IDLE;
         r_cursor <= '0;
         r_count  <= '0;
         r_mask   <= '0;
         r_values <= '0;
      end else begin
         r_state  <= w_next_state;
         r_cursor <= w_next_cursor;
         if (w_load) begin
            r_mask   <= in_mask;
            r_values <= in_values;
            r_count  <= w_in_count;
         end
      end
   end

   assign o_dbg_state = r_state;

endmodule
